rl_force_collector: RTL and testbench

//  Sink side of the range-limited force pipeline. Issues the start strobe to the pipeline,

---
 rtl/rl_force_collector.sv | 219 +++++++++++++++++++++
 tb/tb_rl_force_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_force_collector.sv
// rl_force_collector: sink of the range-limited force pipeline. Starts the pipeline,
// sums every PAIRS_PER_PARTICLE force triplets into a per-particle total with
// saturation, and stores the totals in a force cache readable by the motion stage.
module rl_force_collector #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned PAIRS_PER_PARTICLE  = 8,
    parameter int unsigned PARTICLE_NUM        = 64,
    parameter int unsigned PARTICLE_ADDR_WIDTH = 6,
    parameter int unsigned PAIR_CNT_WIDTH      = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           go,
    output logic                           pipe_start,
    input  logic [DATA_WIDTH-1:0]          forceoutput_x,
    input  logic [DATA_WIDTH-1:0]          forceoutput_y,
    input  logic [DATA_WIDTH-1:0]          forceoutput_z,
    input  logic                           forceoutput_valid,
    input  logic                           pipe_done,
    input  logic [PARTICLE_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_x,
    output logic [DATA_WIDTH-1:0]          rd_y,
    output logic [DATA_WIDTH-1:0]          rd_z,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    // Particle index needs one extra bit so that "all entries written" is representable.
    localparam int unsigned IDX_W   = PARTICLE_ADDR_WIDTH + 1;
    localparam int unsigned ENTRY_W = 3 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_COLLECT = 3'd2,
        S_FLUSH   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_pipe_start_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    logic [DATA_WIDTH-1:0]     r_acc_x;
    logic [DATA_WIDTH-1:0]     r_acc_y;
    logic [DATA_WIDTH-1:0]     r_acc_z;
    logic [PAIR_CNT_WIDTH-1:0] r_pair_cnt;
    logic [IDX_W-1:0]          r_particle_idx;
    logic                      r_overflow;

    logic [ENTRY_W-1:0] r_cache [PARTICLE_NUM];

    logic [DATA_WIDTH:0]   w_sat_x;
    logic [DATA_WIDTH:0]   w_sat_y;
    logic [DATA_WIDTH:0]   w_sat_z;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_last_pair;
    logic                  w_clamp;
    logic                  w_wr_en;
    logic [ENTRY_W-1:0]    w_wr_data;
    logic [PARTICLE_ADDR_WIDTH-1:0] w_wr_addr;

    // Signed add with clamp; MSB of the result flags that a clamp occurred.
    function automatic logic [DATA_WIDTH:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            sat_add = {1'b1, s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}};
        end else begin
            sat_add = {1'b0, s[DATA_WIDTH-1:0]};
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; pipe_done is only honoured while collecting.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (go) w_next_state = S_ARM;
            S_ARM:     w_next_state = S_COLLECT;
            S_COLLECT: if (pipe_done) w_next_state = S_FLUSH;
            S_FLUSH:   w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs align with it.
    always_comb begin
        w_pipe_start_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        case (w_next_state)
            S_ARM: begin
                w_pipe_start_nxt = 1'b1;
                w_busy_nxt       = 1'b1;
            end
            S_COLLECT: w_busy_nxt = 1'b1;
            S_FLUSH:   w_busy_nxt = 1'b1;
            S_DONE:    w_done_nxt = 1'b1;
            default: begin
                w_pipe_start_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
                w_done_nxt       = 1'b0;
            end
        endcase
    end

    // Control output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pipe_start <= w_pipe_start_nxt;
            busy       <= w_busy_nxt;
            done       <= w_done_nxt;
        end
    end

    // Accumulate/drop decisions and cache write port.
    always_comb begin
        w_sat_x     = sat_add(r_acc_x, forceoutput_x);
        w_sat_y     = sat_add(r_acc_y, forceoutput_y);
        w_sat_z     = sat_add(r_acc_z, forceoutput_z);
        w_full      = (r_particle_idx == IDX_W'(PARTICLE_NUM));
        w_accept    = (r_state == S_COLLECT) && forceoutput_valid && !w_full;
        w_drop      = (r_state == S_COLLECT) && forceoutput_valid && w_full;
        w_last_pair = (r_pair_cnt == PAIR_CNT_WIDTH'(PAIRS_PER_PARTICLE - 1));
        w_clamp     = w_accept && (w_sat_x[DATA_WIDTH] || w_sat_y[DATA_WIDTH] ||
                                   w_sat_z[DATA_WIDTH]);
        w_wr_addr   = r_particle_idx[PARTICLE_ADDR_WIDTH-1:0];
        w_wr_en     = 1'b0;
        w_wr_data   = {r_acc_x, r_acc_y, r_acc_z};
        if (w_accept && w_last_pair) begin
            w_wr_en   = 1'b1;
            w_wr_data = {w_sat_x[DATA_WIDTH-1:0], w_sat_y[DATA_WIDTH-1:0],
                         w_sat_z[DATA_WIDTH-1:0]};
        end else if ((r_state == S_FLUSH) && (r_pair_cnt != '0) && !w_full) begin
            w_wr_en   = 1'b1;
        end
    end

    // Accumulators, counters and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_x        <= '0;
            r_acc_y        <= '0;
            r_acc_z        <= '0;
            r_pair_cnt     <= '0;
            r_particle_idx <= '0;
            r_overflow     <= 1'b0;
        end else if (r_state == S_ARM) begin
            r_acc_x        <= '0;
            r_acc_y        <= '0;
            r_acc_z        <= '0;
            r_pair_cnt     <= '0;
            r_particle_idx <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last_pair) begin
                    r_acc_x        <= '0;
                    r_acc_y        <= '0;
                    r_acc_z        <= '0;
                    r_pair_cnt     <= '0;
                    r_particle_idx <= r_particle_idx + IDX_W'(1);
                end else begin
                    r_acc_x    <= w_sat_x[DATA_WIDTH-1:0];
                    r_acc_y    <= w_sat_y[DATA_WIDTH-1:0];
                    r_acc_z    <= w_sat_z[DATA_WIDTH-1:0];
                    r_pair_cnt <= r_pair_cnt + PAIR_CNT_WIDTH'(1);
                end
            end
            if (w_clamp || w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign overflow = r_overflow;

    // Force cache storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_cache[w_wr_addr] <= w_wr_data;
        end
    end

    // Registered read port; a same-edge write is not forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_x <= '0;
            rd_y <= '0;
            rd_z <= '0;
        end else begin
            {rd_x, rd_y, rd_z} <= r_cache[rd_addr];
        end
    end

endmodule

// File: tb/tb_rl_force_collector.sv
// Scoreboard bench for rl_force_collector: a queue-based reference model predicts
// cache contents and the end-of-run overflow flag; a monitor compares on reads/done.
module tb_rl_force_collector;

    localparam int NP  = 64;
    localparam int PPP = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        pipe_start;
    logic [31:0] fx, fy, fz;
    logic        fv;
    logic        pdone;
    logic [5:0]  rd_addr;
    logic [31:0] rd_x, rd_y, rd_z;
    logic        busy, done, overflow;

    rl_force_collector dut (
        .clk(clk), .rst_n(rst_n), .go(go), .pipe_start(pipe_start),
        .forceoutput_x(fx), .forceoutput_y(fy), .forceoutput_z(fz),
        .forceoutput_valid(fv), .pipe_done(pdone), .rd_addr(rd_addr),
        .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: cache image persists across runs.
    int mx [NP];
    int my [NP];
    int mz [NP];
    bit known [NP];
    int qx[$], qy[$], qz[$];
    int wr_idx[$];

    typedef struct {
        int          addr;
        logic [95:0] exp;
    } rd_exp_t;
    rd_exp_t rd_q[$];
    bit      ovf_q[$];

    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;

    always @(posedge clk) rd_pend <= rd_req;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or a done pulse.
    always @(negedge clk) begin
        rd_exp_t e;
        bit      eo;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected actual=%h required=none", {rd_x, rd_y, rd_z});
            end else begin
                e = rd_q.pop_front();
                check($sformatf("rd_cache[%0d]", e.addr), {rd_x, rd_y, rd_z}, e.exp);
            end
        end
        if (done) begin
            if (ovf_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected actual=1 required=0");
            end else begin
                eo = ovf_q.pop_front();
                check("done_overflow", 96'(overflow), 96'(eo));
            end
        end
    end

    function automatic longint sat32(input longint s, inout bit ovf);
        if (s > MAXV) begin ovf = 1'b1; return MAXV; end
        if (s < MINV) begin ovf = 1'b1; return MINV; end
        return s;
    endfunction

    function automatic void store(input int idx, input longint ax, input longint ay, input longint az);
        mx[idx] = int'(ax); my[idx] = int'(ay); mz[idx] = int'(az);
        known[idx] = 1'b1;
        wr_idx.push_back(idx);
    endfunction

    // Groups triplets into particles of PPP, saturating each running sum.
    function automatic void model_run();
        longint ax = 0, ay = 0, az = 0;
        int cnt = 0, idx = 0;
        bit ovf = 1'b0;
        wr_idx.delete();
        for (int i = 0; i < qx.size(); i++) begin
            if (idx == NP) begin
                ovf = 1'b1;
                continue;
            end
            ax = sat32(ax + longint'(qx[i]), ovf);
            ay = sat32(ay + longint'(qy[i]), ovf);
            az = sat32(az + longint'(qz[i]), ovf);
            cnt++;
            if (cnt == PPP) begin
                store(idx, ax, ay, az);
                idx++; cnt = 0; ax = 0; ay = 0; az = 0;
            end
        end
        if (cnt != 0 && idx < NP) store(idx, ax, ay, az);
        ovf_q.push_back(ovf);
    endfunction

    task automatic fill_const(input int n, input int x, input int y, input int z);
        qx.delete(); qy.delete(); qz.delete();
        for (int i = 0; i < n; i++) begin
            qx.push_back(x); qy.push_back(y); qz.push_back(z);
        end
    endtask

    task automatic fill_rand(input int n, input bit big);
        qx.delete(); qy.delete(); qz.delete();
        for (int i = 0; i < n; i++) begin
            if (big) begin
                qx.push_back(int'($urandom)); qy.push_back(int'($urandom)); qz.push_back(int'($urandom));
            end else begin
                qx.push_back(int'($urandom_range(20000)) - 10000);
                qy.push_back(int'($urandom_range(20000)) - 10000);
                qz.push_back(int'($urandom_range(20000)) - 10000);
            end
        end
    endtask

    task automatic issue_read(input int a);
        rd_exp_t e;
        e.addr = a;
        e.exp  = {mx[a], my[a], mz[a]};
        rd_addr = 6'(a);
        rd_req  = 1'b1;
        rd_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic readback();
        int a;
        foreach (wr_idx[i]) issue_read(wr_idx[i]);
        for (int k = 0; k < 2; k++) begin
            a = int'($urandom_range(NP - 1));
            if (known[a]) issue_read(a);
        end
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One full run: go, stream qx/qy/qz with optional gaps, pipe_done, then readback.
    task automatic do_run(input bit same_done, input int gap_pct);
        int n;
        int lat;
        n = qx.size();
        model_run();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("pipe_start_high", 96'(pipe_start), 96'(1));
        check("busy_in_arm", 96'(busy), 96'(1));
        @(negedge clk);
        check("pipe_start_low", 96'(pipe_start), 96'(0));
        check("overflow_cleared", 96'(overflow), 96'(0));
        pdone = 1'b0;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                fv = 1'b0; fx = $urandom; fy = $urandom; fz = $urandom;
                @(negedge clk);
            end
            fv = 1'b1; fx = qx[i]; fy = qy[i]; fz = qz[i];
            pdone = same_done && (i == n - 1);
            if (!pdone) @(negedge clk);
        end
        if (!pdone) begin
            fv = 1'b0;
            pdone = 1'b1;
        end
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            fv = 1'b0; pdone = 1'b0; fx = $urandom;
            lat++;
            if (done) break;
        end
        check("done_latency", 96'(lat), 96'(2));
        check("busy_at_done", 96'(busy), 96'(0));
        @(negedge clk);
        readback();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go = 1'b1; fv = 1'b1; pdone = 1'b0;
        fx = 32'd7; fy = 32'd7; fz = 32'd7; rd_addr = '0;
        for (int i = 0; i < NP; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pipe_start", 96'(pipe_start), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_done", 96'(done), 96'(0));
        check("rst_overflow", 96'(overflow), 96'(0));
        check("rst_rd", {rd_x, rd_y, rd_z}, 96'(0));
        go = 1'b0; fv = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 96'(busy), 96'(0));

        // Two full particles of constant forces.
        fill_const(16, 1, -2, 3);
        do_run(1'b0, 0);

        // Partial particle flushed when pipe_done coincides with the last triplet.
        fill_const(11, 5, -1, 9);
        do_run(1'b1, 0);

        // Positive and negative saturation.
        fill_const(8, 32'h7FFFFFF0, -2147483632, 0);
        do_run(1'b0, 0);

        // Randomized runs with gaps; the first also verifies overflow was cleared.
        for (int r = 0; r < 3; r++) begin
            fill_rand(int'($urandom_range(40)), 1'b0);
            do_run(1'($urandom_range(1)), 30);
        end

        // Cache full: last three triplets dropped, no wrap.
        fill_rand(NP * PPP + 3, 1'b0);
        do_run(1'b0, 0);

        // Reset mid-collect; partial sums must vanish.
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            fv = 1'b1; fx = 32'd7; fy = 32'd7; fz = 32'd7;
            @(negedge clk);
        end
        fv = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 96'(busy), 96'(0));
        check("midrst_overflow", 96'(overflow), 96'(0));
        check("midrst_pipe_start", 96'(pipe_start), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_const(8, 2, 0, 0);
        do_run(1'b0, 0);

        // Large random values exercise saturation with gaps.
        fill_rand(int'($urandom_range(30)) + 10, 1'b1);
        do_run(1'b1, 20);

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 96'(rd_q.size()), 96'(0));
        check("done_queue_drained", 96'(ovf_q.size()), 96'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
